// File: rtl/box_pkg.sv
// Shared constants, state encoding and screen-bounds helper for the box plotter.
package box_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_WHITE = 3'b111;
    localparam logic [2:0] COL_BLACK = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } box_state_t;

    // Sums arrive one bit wider than the screen coordinates so overflow cannot wrap on-screen.
    function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py);
        return (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
    endfunction

endpackage

// File: rtl/box_plotter_if.sv
// Request/pixel bundle between a box sequencer (master) and the box plotter (slave).
interface box_plotter_if;
    import box_pkg::*;

    // A request transfers on a rising clock edge where start=1 and ready=1; start while
    // ready=0 is dropped, never held over. plot qualifies x_out/y_out/colour_out each cycle.
    logic       start;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic       ready;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       done;
    box_state_t state;

    modport master (
        output start, x_in, y_in, colour_in,
        input  ready, x_out, y_out, colour_out, plot, done, state
    );

    modport slave (
        input  start, x_in, y_in, colour_in,
        output ready, x_out, y_out, colour_out, plot, done, state
    );

endinterface

// File: rtl/box_scan_counter.sv
// Row-major column/row scan over a BOX_W x BOX_H block with a last-pixel flag.
module box_scan_counter #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    output logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] col_nxt,
    output logic [3:0] row_nxt,
    output logic       last
);

    localparam logic [3:0] COL_MAX = 4'(BOX_W - 1);
    localparam logic [3:0] ROW_MAX = 4'(BOX_H - 1);

    // The next values are exported so the caller can register the upcoming pixel directly.
    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (clear) begin
            col_nxt = 4'd0;
            row_nxt = 4'd0;
        end else if (en) begin
            if (col == COL_MAX) begin
                col_nxt = 4'd0;
                row_nxt = row + 4'd1;
            end else begin
                col_nxt = col + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= 4'd0;
            row <= 4'd0;
        end else begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end

    assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/box_plotter.sv
// Rasterises one box request into BOX_W x BOX_H single-pixel plot writes for the VGA adapter.
module box_plotter
    import box_pkg::*;
#(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4
) (
    input  logic          clk,
    input  logic          reset,
    box_plotter_if.slave  bus
);

    box_state_t state;
    box_state_t state_nxt;

    logic       ready;
    logic       load;
    logic       advance;
    logic       last;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] col_nxt;
    logic [3:0] row_nxt;

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [2:0] base_c;
    logic [7:0] src_x;
    logic [6:0] src_y;
    logic [2:0] src_c;
    logic [8:0] px;
    logic [7:0] py;

    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] c_q;
    logic       plot_q;
    logic       done_q;

    box_scan_counter #(
        .BOX_W (BOX_W),
        .BOX_H (BOX_H)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .clear   (load),
        .en      (advance),
        .col     (col),
        .row     (row),
        .col_nxt (col_nxt),
        .row_nxt (row_nxt),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = DRAW;
            DRAW:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready   = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state)
            IDLE:    begin ready = 1'b1; load = bus.start; end
            DRAW:    advance = !last;
            default: ;
        endcase
    end

    // Output registers are loaded with the pixel the counters move to, so each plotted
    // pixel lines up with the DRAW cycle whose counter value it represents.
    assign src_x = load ? bus.x_in      : base_x;
    assign src_y = load ? bus.y_in      : base_y;
    assign src_c = load ? bus.colour_in : base_c;
    assign px    = {1'b0, src_x} + {5'd0, col_nxt};
    assign py    = {1'b0, src_y} + {4'd0, row_nxt};

    always_ff @(posedge clk) begin
        if (reset) begin
            base_x <= 8'd0;
            base_y <= 7'd0;
            base_c <= COL_BLACK;
            x_q    <= 8'd0;
            y_q    <= 7'd0;
            c_q    <= COL_BLACK;
            plot_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (load) begin
                base_x <= bus.x_in;
                base_y <= bus.y_in;
                base_c <= bus.colour_in;
            end
            done_q <= (state == DRAW) && last;
            if (load || advance) begin
                x_q    <= px[7:0];
                y_q    <= py[6:0];
                c_q    <= src_c;
                plot_q <= on_screen(px, py);
            end else begin
                plot_q <= 1'b0;
            end
        end
    end

    assign bus.ready      = ready;
    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.colour_out = c_q;
    assign bus.plot       = plot_q;
    assign bus.done       = done_q;
    assign bus.state      = state;

endmodule

// File: tb/tb_box_plotter.sv
// Self-checking bench for box_plotter: 4x4 instance driven from a vector table and corner
// sequences, plus a 1x1 instance for the single-pixel edge case.
module tb_box_plotter;
    import box_pkg::*;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    box_plotter_if if_a ();
    box_plotter_if if_b ();

    box_plotter #(.BOX_W(W), .BOX_H(H)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    box_plotter #(.BOX_W(1), .BOX_H(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q[$];

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         inject_at;
        int         exp_plots;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference rasteriser: pushes every on-screen pixel of a box in row-major order.
    function automatic int push_box(input int x, input int y, input logic [2:0] c);
        int n = 0;
        for (int r = 0; r < H; r++) begin
            for (int k = 0; k < W; k++) begin
                int px;
                int py;
                px = x + k;
                py = y + r;
                if (px < 160 && py < 120) begin
                    exp_q.push_back({8'(px), 7'(py), c});
                    n++;
                end
            end
        end
        return n;
    endfunction

    task automatic drive_start(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        if_a.start     = 1'b1;
        if_a.x_in      = x;
        if_a.y_in      = y;
        if_a.colour_in = c;
    endtask

    task automatic take_pixel(input string name);
        logic [17:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected pixel got (%0d,%0d) c=%0d expected none", name,
                     if_a.x_out, if_a.y_out, if_a.colour_out);
        end else begin
            e = exp_q.pop_front();
            check({name, " pixel"}, 32'({if_a.x_out, if_a.y_out, if_a.colour_out}), 32'(e));
        end
    endtask

    // Called straight after the accepting edge; walks DRAW, DONE and the first IDLE cycle.
    task automatic draw_check(input string name, input int exp_plots, input int inject_at,
                              input bit hold_start);
        int plots = 0;
        for (int k = 1; k <= NPIX + 2; k++) begin
            @(negedge clk);
            if (k <= NPIX) begin
                check({name, " ready in draw"}, 32'(if_a.ready), 32'd0);
                check({name, " done in draw"}, 32'(if_a.done), 32'd0);
                if (if_a.plot) begin
                    plots++;
                    take_pixel(name);
                end
            end else if (k == NPIX + 1) begin
                check({name, " done pulse"}, 32'(if_a.done), 32'd1);
                check({name, " plot in done"}, 32'(if_a.plot), 32'd0);
                check({name, " ready in done"}, 32'(if_a.ready), 32'd0);
            end else begin
                check({name, " ready back"}, 32'(if_a.ready), 32'd1);
                check({name, " done cleared"}, 32'(if_a.done), 32'd0);
            end
            if (k == 1 && !hold_start) if_a.start = 1'b0;
            if (inject_at != 0) begin
                if (k == inject_at) drive_start(8'd38, 7'd19, COL_WHITE);
                else if (k == inject_at + 1) if_a.start = 1'b0;
            end
        end
        check({name, " plot count"}, 32'(plots), 32'(exp_plots));
        check({name, " queue drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        bit quiet;

        vecs[0] = '{8'd43,  7'd7,   3'b111, 0, 16};
        vecs[1] = '{8'd158, 7'd118, 3'b010, 0, 4};
        vecs[2] = '{8'd123, 7'd7,   3'b101, 3, 16};
        vecs[3] = '{8'd0,   7'd0,   3'b001, 0, 16};
        vecs[4] = '{8'd157, 7'd0,   3'b011, 0, 12};
        vecs[5] = '{8'd0,   7'd117, 3'b100, 0, 12};
        vecs[6] = '{8'd159, 7'd119, 3'b110, 0, 1};
        vecs[7] = '{8'd200, 7'd50,  3'b111, 0, 0};

        // Clock/reset, with start held high through reset to show it is ignored.
        reset = 1'b1;
        if_a.start = 1'b1; if_a.x_in = 8'd9; if_a.y_in = 7'd9; if_a.colour_in = 3'b101;
        if_b.start = 1'b0; if_b.x_in = 8'd0; if_b.y_in = 7'd0; if_b.colour_in = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset state", 32'(if_a.state), 32'(IDLE));
        check("reset ready", 32'(if_a.ready), 32'd1);
        check("reset plot", 32'(if_a.plot), 32'd0);
        check("reset done", 32'(if_a.done), 32'd0);
        check("reset x_out", 32'(if_a.x_out), 32'd0);
        check("reset y_out", 32'(if_a.y_out), 32'd0);
        check("reset colour_out", 32'(if_a.colour_out), 32'd0);
        if_a.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            drive_start(vecs[i].x, vecs[i].y, vecs[i].c);
            n = push_box(int'(vecs[i].x), int'(vecs[i].y), vecs[i].c);
            @(posedge clk);
            draw_check($sformatf("vec%0d", i), vecs[i].exp_plots, vecs[i].inject_at, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d idle ready", i), 32'(if_a.ready), 32'd1);
            check($sformatf("vec%0d idle plot", i), 32'(if_a.plot), 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            logic [7:0] rx;
            logic [6:0] ry;
            logic [2:0] rc;
            rx = 8'($urandom_range(0, 170));
            ry = 7'($urandom_range(0, 127));
            rc = 3'($urandom_range(0, 7));
            drive_start(rx, ry, rc);
            n = push_box(int'(rx), int'(ry), rc);
            @(posedge clk);
            draw_check($sformatf("rand%0d", i), n, 0, 1'b0);
        end

        // Reset in the fifth DRAW cycle aborts the box without a done pulse.
        @(negedge clk);
        drive_start(8'd118, 7'd46, 3'b100);
        n = push_box(118, 46, 3'b100);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) if_a.start = 1'b0;
            check("abort plot", 32'(if_a.plot), 32'd1);
            take_pixel("abort");
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort state", 32'(if_a.state), 32'(IDLE));
        check("abort ready", 32'(if_a.ready), 32'd1);
        check("abort plot off", 32'(if_a.plot), 32'd0);
        check("abort done", 32'(if_a.done), 32'd0);
        check("abort x_out", 32'(if_a.x_out), 32'd0);
        check("abort y_out", 32'(if_a.y_out), 32'd0);
        check("abort colour_out", 32'(if_a.colour_out), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        quiet = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if_a.done || if_a.plot) quiet = 1'b0;
        end
        check("abort no done", 32'(quiet), 32'd1);
        drive_start(8'd43, 7'd40, 3'b011);
        n = push_box(43, 40, 3'b011);
        @(posedge clk);
        draw_check("after reset", 16, 0, 1'b0);

        // Back-to-back: start held high, second request presented once ready rises.
        drive_start(8'd43, 7'd46, 3'b110);
        n = push_box(43, 46, 3'b110);
        @(posedge clk);
        draw_check("b2b first", 16, 0, 1'b1);
        drive_start(8'd43, 7'd64, 3'b001);
        n = push_box(43, 64, 3'b001);
        @(posedge clk);
        draw_check("b2b second", 16, 0, 1'b0);

        // Single-pixel instance.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if_b.start     = 1'b1;
            if_b.x_in      = (i == 0) ? 8'd0 : 8'd5;
            if_b.y_in      = (i == 0) ? 7'd0 : 7'd9;
            if_b.colour_in = (i == 0) ? COL_WHITE : 3'b010;
            @(posedge clk);
            @(negedge clk);
            if_b.start = 1'b0;
            check("1x1 plot", 32'(if_b.plot), 32'd1);
            check("1x1 x_out", 32'(if_b.x_out), (i == 0) ? 32'd0 : 32'd5);
            check("1x1 y_out", 32'(if_b.y_out), (i == 0) ? 32'd0 : 32'd9);
            check("1x1 colour", 32'(if_b.colour_out), (i == 0) ? 32'd7 : 32'd2);
            check("1x1 ready in draw", 32'(if_b.ready), 32'd0);
            check("1x1 done early", 32'(if_b.done), 32'd0);
            @(negedge clk);
            check("1x1 done pulse", 32'(if_b.done), 32'd1);
            check("1x1 plot off", 32'(if_b.plot), 32'd0);
            @(negedge clk);
            check("1x1 ready back", 32'(if_b.ready), 32'd1);
            check("1x1 done cleared", 32'(if_b.done), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
